// File: rtl/writeback_multi.sv
// writeback_multi: multi-lane writeback stage with architectural HI/LO and an
// optional serialized retirement trace.
//
// Parameters
//   LANES        number of retiring lanes (1..4)
//   TRACE_DEPTH  trace FIFO entries (power of 2, >= LANES, >= 2)
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   mem_*                    per-lane fields from the memory stage (packed, lane 0 in LSBs)
//   stall, flush             hold / clear the WB register (flush wins)
//   wb_valid, wb_we,
//   wb_writereg, wb_result   registered regfile write ports
//   hilo_hi, hilo_lo         architectural HI/LO
//   stall_req                upstream stall request (trace FIFO nearly full)
//   dbg_pc, dbg_we,
//   dbg_wnum, dbg_wdata      trace FIFO head, all zero when the FIFO is empty
//
// Build option
//   WB_DEBUG_TRACE_EN  defined: trace FIFO, stall_req and dbg_* are built.
//                      undefined: stall_req and dbg_* tied to zero.
module writeback_multi #(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    mem_valid,
    input  logic [LANES*32-1:0] mem_pc,
    input  logic [LANES*5-1:0]  mem_writereg,
    input  logic [LANES*32-1:0] mem_result,
    input  logic [LANES*4-1:0]  mem_regwrite,
    input  logic [LANES-1:0]    mem_hi_we,
    input  logic [LANES-1:0]    mem_lo_we,
    input  logic [LANES*32-1:0] mem_hi,
    input  logic [LANES*32-1:0] mem_lo,
    input  logic                stall,
    input  logic                flush,
    output logic [LANES-1:0]    wb_valid,
    output logic [LANES*4-1:0]  wb_we,
    output logic [LANES*5-1:0]  wb_writereg,
    output logic [LANES*32-1:0] wb_result,
    output logic [31:0]         hilo_hi,
    output logic [31:0]         hilo_lo,
    output logic                stall_req,
    output logic [31:0]         dbg_pc,
    output logic [3:0]          dbg_we,
    output logic [4:0]          dbg_wnum,
    output logic [31:0]         dbg_wdata
);

    logic                advance;
    logic [LANES-1:0]    vld_p1;
    logic [LANES-1:0]    hi_we_p1;
    logic [LANES-1:0]    lo_we_p1;
    logic [LANES*32-1:0] pc_p1;
    logic [LANES*32-1:0] res_p1;
    logic [LANES*32-1:0] hi_p1;
    logic [LANES*32-1:0] lo_p1;
    logic [LANES*5-1:0]  wreg_p1;
    logic [LANES*4-1:0]  rw_p1;

    // ---- stage p1: WB register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= '0;
            hi_we_p1 <= '0;
            lo_we_p1 <= '0;
            pc_p1    <= '0;
            res_p1   <= '0;
            hi_p1    <= '0;
            lo_p1    <= '0;
            wreg_p1  <= '0;
            rw_p1    <= '0;
        end else if (flush) begin
            vld_p1 <= '0;
        end else if (advance) begin
            vld_p1   <= mem_valid;
            hi_we_p1 <= mem_hi_we;
            lo_we_p1 <= mem_lo_we;
            pc_p1    <= mem_pc;
            res_p1   <= mem_result;
            hi_p1    <= mem_hi;
            lo_p1    <= mem_lo;
            wreg_p1  <= mem_writereg;
            rw_p1    <= mem_regwrite;
        end
    end

    assign wb_valid    = vld_p1;
    assign wb_writereg = wreg_p1;
    assign wb_result   = res_p1;

    // Writes to GPR 0 are architecturally discarded, so they never reach the port.
    always_comb begin
        wb_we = '0;
        for (int l = 0; l < LANES; l++) begin
            if (vld_p1[l] && (wreg_p1[l*5 +: 5] != 5'd0))
                wb_we[l*4 +: 4] = rw_p1[l*4 +: 4];
        end
    end

    // ---- stage p2: HI/LO architectural state ----
    // Ascending loop: the last assignment (highest lane) wins on conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_hi <= '0;
            hilo_lo <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (vld_p1[l] && hi_we_p1[l]) hilo_hi <= hi_p1[l*32 +: 32];
                if (vld_p1[l] && lo_we_p1[l]) hilo_lo <= lo_p1[l*32 +: 32];
            end
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CW = $clog2(TRACE_DEPTH + 1);
    localparam int EW = 32 + 4 + 5 + 32;

    logic [EW-1:0]    fifo_mem [TRACE_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             commit;
    logic             pop;
    logic [LANES-1:0] push_en;
    logic [PW-1:0]    wr_idx [LANES];
    logic [CW-1:0]    num_push;
    logic [EW-1:0]    head;

    // Based on the registered count only, so no path from stall/flush.
    assign stall_req = (CW'(TRACE_DEPTH) - count) < CW'(LANES);
    assign advance   = !stall && !stall_req;
    assign commit    = advance || flush;
    assign pop       = (count != '0);

    // Pushing lanes are packed into consecutive slots in ascending lane order.
    always_comb begin
        num_push = '0;
        push_en  = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_idx[l]  = wr_ptr + PW'(num_push);
            push_en[l] = commit && (wb_we[l*4 +: 4] != 4'd0);
            num_push   = num_push + CW'(push_en[l]);
        end
    end

    // ---- stage p2: trace FIFO ----
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (push_en[l])
                fifo_mem[wr_idx[l]] <= {pc_p1[l*32 +: 32], wb_we[l*4 +: 4],
                                        wreg_p1[l*5 +: 5], res_p1[l*32 +: 32]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(num_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + num_push - CW'(pop);
        end
    end

    assign head      = pop ? fifo_mem[rd_ptr] : '0;
    assign dbg_pc    = head[72:41];
    assign dbg_we    = head[40:37];
    assign dbg_wnum  = head[36:32];
    assign dbg_wdata = head[31:0];
`else
    logic unused_trace;

    assign stall_req    = 1'b0;
    assign advance      = !stall;
    assign dbg_pc       = '0;
    assign dbg_we       = '0;
    assign dbg_wnum     = '0;
    assign dbg_wdata    = '0;
    assign unused_trace = ^pc_p1 ^ (TRACE_DEPTH > 0);
`endif

endmodule

// File: tb/tb_writeback_multi.sv
module tb_writeback_multi;

    localparam int L = 2;
    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [L-1:0]    mem_valid;
    logic [L*32-1:0] mem_pc;
    logic [L*5-1:0]  mem_writereg;
    logic [L*32-1:0] mem_result;
    logic [L*4-1:0]  mem_regwrite;
    logic [L-1:0]    mem_hi_we;
    logic [L-1:0]    mem_lo_we;
    logic [L*32-1:0] mem_hi;
    logic [L*32-1:0] mem_lo;
    logic            stall;
    logic            flush;
    logic [L-1:0]    wb_valid;
    logic [L*4-1:0]  wb_we;
    logic [L*5-1:0]  wb_writereg;
    logic [L*32-1:0] wb_result;
    logic [31:0]     hilo_hi;
    logic [31:0]     hilo_lo;
    logic            stall_req;
    logic [31:0]     dbg_pc;
    logic [3:0]      dbg_we;
    logic [4:0]      dbg_wnum;
    logic [31:0]     dbg_wdata;

    always #5 clk = ~clk;

    writeback_multi #(.LANES(L), .TRACE_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_writereg(mem_writereg),
        .mem_result(mem_result), .mem_regwrite(mem_regwrite),
        .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_writereg(wb_writereg), .wb_result(wb_result),
        .hilo_hi(hilo_hi), .hilo_lo(hilo_lo), .stall_req(stall_req),
        .dbg_pc(dbg_pc), .dbg_we(dbg_we), .dbg_wnum(dbg_wnum), .dbg_wdata(dbg_wdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] data;
    } trace_t;

    // Reference model: WB contents, HI/LO and the trace as a plain queue.
    trace_t      exp_q[$];
    logic        m_vld  [L];
    logic [31:0] m_pc   [L];
    logic [4:0]  m_wreg [L];
    logic [31:0] m_res  [L];
    logic [3:0]  m_rw   [L];
    logic        m_hiwe [L];
    logic        m_lowe [L];
    logic [31:0] m_hi   [L];
    logic [31:0] m_lo   [L];
    logic [31:0] m_hilo_hi;
    logic [31:0] m_hilo_lo;
    bit          m_adv;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_seen = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_sreq();
`ifdef WB_DEBUG_TRACE_EN
        return (D - exp_q.size()) < L;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        for (int l = 0; l < L; l++) begin
            m_vld[l] = 0; m_pc[l] = 0; m_wreg[l] = 0; m_res[l] = 0; m_rw[l] = 0;
            m_hiwe[l] = 0; m_lowe[l] = 0; m_hi[l] = 0; m_lo[l] = 0;
        end
        m_hilo_hi = 0;
        m_hilo_lo = 0;
        exp_q.delete();
    endtask

    // Evaluated at each rising edge with the inputs presented during that cycle.
    task automatic model_step();
        bit adv;
        trace_t t;
        adv   = !stall && !model_sreq();
        m_adv = adv;
        for (int l = L - 1; l >= 0; l--) begin
            if (m_vld[l] && m_hiwe[l]) begin m_hilo_hi = m_hi[l]; break; end
        end
        for (int l = L - 1; l >= 0; l--) begin
            if (m_vld[l] && m_lowe[l]) begin m_hilo_lo = m_lo[l]; break; end
        end
`ifdef WB_DEBUG_TRACE_EN
        if (exp_q.size() > 0) exp_q.delete(0);
        if (adv || flush) begin
            for (int l = 0; l < L; l++) begin
                if (m_vld[l] && m_wreg[l] != 0 && m_rw[l] != 0) begin
                    t.pc = m_pc[l]; t.we = m_rw[l]; t.wnum = m_wreg[l]; t.data = m_res[l];
                    exp_q.push_back(t);
                end
            end
        end
`endif
        if (flush) begin
            for (int l = 0; l < L; l++) m_vld[l] = 0;
        end else if (adv) begin
            for (int l = 0; l < L; l++) begin
                m_vld[l]  = mem_valid[l];
                m_pc[l]   = mem_pc[l*32 +: 32];
                m_wreg[l] = mem_writereg[l*5 +: 5];
                m_res[l]  = mem_result[l*32 +: 32];
                m_rw[l]   = mem_regwrite[l*4 +: 4];
                m_hiwe[l] = mem_hi_we[l];
                m_lowe[l] = mem_lo_we[l];
                m_hi[l]   = mem_hi[l*32 +: 32];
                m_lo[l]   = mem_lo[l*32 +: 32];
            end
        end
    endtask

    task automatic compare_all();
        trace_t h;
        logic [3:0] ewe;
        for (int l = 0; l < L; l++) begin
            check_val($sformatf("wb_valid[%0d]", l), wb_valid[l], m_vld[l]);
            ewe = (m_vld[l] && m_wreg[l] != 0) ? m_rw[l] : 4'd0;
            check_val($sformatf("wb_we[%0d]", l), wb_we[l*4 +: 4], ewe);
            if (m_vld[l]) begin
                check_val($sformatf("wb_writereg[%0d]", l), wb_writereg[l*5 +: 5], m_wreg[l]);
                check_val($sformatf("wb_result[%0d]", l), wb_result[l*32 +: 32], m_res[l]);
            end
        end
        check_val("hilo_hi", hilo_hi, m_hilo_hi);
        check_val("hilo_lo", hilo_lo, m_hilo_lo);
        check_val("stall_req", stall_req, model_sreq());
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        check_val("dbg_pc", dbg_pc, h.pc);
        check_val("dbg_we", dbg_we, h.we);
        check_val("dbg_wnum", dbg_wnum, h.wnum);
        check_val("dbg_wdata", dbg_wdata, h.data);
        if (dbg_we != 0) dut_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        mem_valid = '0; mem_pc = '0; mem_writereg = '0; mem_result = '0;
        mem_regwrite = '0; mem_hi_we = '0; mem_lo_we = '0; mem_hi = '0; mem_lo = '0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic v, input logic [31:0] pc,
                            input logic [4:0] wr, input logic [31:0] res, input logic [3:0] rw,
                            input logic hwe, input logic lwe,
                            input logic [31:0] hi, input logic [31:0] lo);
        mem_valid[l]           = v;
        mem_pc[l*32 +: 32]     = pc;
        mem_writereg[l*5 +: 5] = wr;
        mem_result[l*32 +: 32] = res;
        mem_regwrite[l*4 +: 4] = rw;
        mem_hi_we[l]           = hwe;
        mem_lo_we[l]           = lwe;
        mem_hi[l*32 +: 32]     = hi;
        mem_lo[l*32 +: 32]     = lo;
    endtask

    task automatic set_pair(input int i);
        for (int l = 0; l < L; l++)
            set_lane(l, 1'b1, 32'h1000 + 32'(8 * i + 4 * l), 5'(1 + 2 * i + l),
                     32'hA000 + 32'(16 * i + l), 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic apply_reset();
        idle();
        rst = 1'b0;
        #1;
        check_val("rst_dbg_we", dbg_we, 4'd0);
        check_val("rst_dbg_pc", dbg_pc, 32'd0);
        check_val("rst_wb_valid", wb_valid, '0);
        check_val("rst_hilo_hi", hilo_hi, 32'd0);
        check_val("rst_stall_req", stall_req, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int i;
        int budget;
        int seen0;
        int exp_pairs;
`ifdef WB_DEBUG_TRACE_EN
        exp_pairs = 2 * 4;
`else
        exp_pairs = 0;
`endif
        idle();
        model_clear();
        #2;
        apply_reset();
        compare_all();

        // Single-lane retire and trace
        set_lane(0, 1'b1, 32'h100, 5'd8, 32'h1234, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        check_val("t036_wb_we", wb_we[3:0], 4'hF);
        idle();
        repeat (3) cycle();

        // Write to GPR 0 is suppressed and not traced
        set_lane(0, 1'b1, 32'h200, 5'd0, 32'hDEAD, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        check_val("t037_wb_we", wb_we[3:0], 4'h0);
        idle();
        repeat (3) cycle();

        // HI conflict: highest lane wins
        set_lane(0, 1'b1, 32'h300, 5'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h11, 32'h33);
        set_lane(1, 1'b1, 32'h304, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h22, 32'h44);
        cycle();
        idle();
        cycle();
        check_val("t038_hilo_hi", hilo_hi, 32'h22);
        check_val("t038_hilo_lo", hilo_lo, 32'h33);
        repeat (2) cycle();

        // Back-to-back dual retire fills the FIFO; every entry must emerge in order
        seen0  = dut_seen;
        i      = 0;
        budget = 0;
        while (i < 4 && budget < 40) begin
            set_pair(i);
            cycle();
            if (m_adv) i++;
            budget++;
        end
        check_val("t039_accepted", i, 4);
        idle();
        repeat (12) cycle();
        check_val("t039_entries", dut_seen - seen0, exp_pairs);

        // Flush while stalled still commits the WB contents
        set_pair(5);
        cycle();
        idle();
        stall = 1'b1;
        flush = 1'b1;
        cycle();
        check_val("t040_wb_valid", wb_valid, '0);
        idle();
        repeat (6) cycle();

        // Reset in the middle of a drain
        set_pair(6);
        cycle();
        set_pair(7);
        cycle();
        idle();
        cycle();
        apply_reset();
        compare_all();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int l = 0; l < L; l++)
                set_lane(l, 1'($urandom), $urandom,
                         ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                         $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                         $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
                compare_all();
            end else begin
                cycle();
            end
        end
        idle();
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
